// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern-detection controller:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - power-on configuration giving legacy "101" overlapping detection
//   - helper that validates a programmed pattern length
// -----------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   // Widest pattern the length field (4 bits) can describe.
   localparam int PAT_W_MAX = 15;

   localparam logic [PAT_W_MAX-1:0] DEF_PAT = 15'b101;
   localparam logic [3:0]           DEF_LEN = 4'd3;
   localparam logic                 DEF_OVL = 1'b1;

   // A pattern length is usable when it is 1..pat_w.
   function automatic logic len_ok(input logic [3:0] len, input int pat_w);
      return (len != 4'd0) && (int'(len) <= pat_w);
   endfunction

endpackage

// File: rtl/seq_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_frame_ctrl_if
// Config / command / bit-stream / status bundle of seq_frame_ctrl.
//   master : agent side, drives config, commands and the serial stream
//   slave  : controller side, returns busy/match/match_cnt/done/err
// -----------------------------------------------------------------------------
interface seq_frame_ctrl_if #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = 8
);
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pat;
   logic [3:0]       cfg_len;
   logic             cfg_ovl;
   logic             start;
   logic [LEN_W-1:0] frame_len;
   logic             abort;
   logic             din;
   logic             din_vld;
   logic             busy;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             done;
   logic             err;

   modport master (
      output cfg_we, cfg_pat, cfg_len, cfg_ovl, start, frame_len, abort,
             din, din_vld,
      input  busy, match, match_cnt, done, err
   );

   modport slave (
      input  cfg_we, cfg_pat, cfg_len, cfg_ovl, start, frame_len, abort,
             din, din_vld,
      output busy, match, match_cnt, done, err
   );
endinterface

// File: rtl/seq_pat_match.sv
// -----------------------------------------------------------------------------
// seq_pat_match
// Bit history, fill counter and masked pattern compare.
//   clk, rst  : clock, async active-high reset
//   i_clr     : clear history and fill (frame start)
//   i_shift   : accept i_din this cycle
//   i_din     : serial bit
//   i_pat     : pattern, bit 0 = most recent
//   i_len     : active pattern length (1..PAT_W)
//   i_ovl     : overlapping matches allowed
//   o_hit     : combinational, i_din completes a match (valid with i_shift)
// -----------------------------------------------------------------------------
module seq_pat_match #(
   parameter int PAT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_shift,
   input  logic             i_din,
   input  logic [PAT_W-1:0] i_pat,
   input  logic [3:0]       i_len,
   input  logic             i_ovl,
   output logic             o_hit
);

   logic [PAT_W-1:0] r_hist;
   logic [3:0]       r_fill;

   logic [PAT_W-1:0] w_hist_nxt;
   logic [PAT_W-1:0] w_mask;
   logic [3:0]       w_fill_inc;

   always_comb begin
      w_hist_nxt = {r_hist[PAT_W-2:0], i_din};
      w_fill_inc = (r_fill >= 4'(PAT_W)) ? 4'(PAT_W) : r_fill + 4'd1;
      w_mask     = '0;
      for (int i = 0; i < PAT_W; i++)
         w_mask[i] = (i < int'(i_len));
      // fill guards against matching on stale/cleared history bits
      o_hit = i_shift && (w_fill_inc >= i_len) &&
              (((w_hist_nxt ^ i_pat) & w_mask) == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (i_clr) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (i_shift) begin
         r_hist <= w_hist_nxt;
         // non-overlap: a hit consumes its bits, next match needs L fresh ones
         r_fill <= (o_hit && !i_ovl) ? 4'd0 : w_fill_inc;
      end
   end

endmodule

// File: rtl/seq_frame_ctrl.sv
// -----------------------------------------------------------------------------
// seq_frame_ctrl
// Programmable serial pattern detector with framed match counting.
//   clk  : clock, rising edge
//   rst  : async active-high reset, forces IDLE immediately
//   bus  : seq_frame_ctrl_if.slave
//          in : cfg_we/cfg_pat/cfg_len/cfg_ovl, start/frame_len, abort,
//               din/din_vld
//          out: busy, match (1-cycle), match_cnt (saturating), done (1-cycle),
//               err (1-cycle rejected command)
// All outputs are registered.
// -----------------------------------------------------------------------------
module seq_frame_ctrl
   import seq_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   seq_frame_ctrl_if.slave   bus
);

   seq_state_e       r_state;
   logic [PAT_W-1:0] r_pat;
   logic [3:0]       r_len;
   logic             r_ovl;
   logic [LEN_W-1:0] r_flen;
   logic [LEN_W-1:0] r_bitcnt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_match;
   logic             r_done;
   logic             r_err;

   logic w_start_ok;
   logic w_shift;
   logic w_hit;
   logic w_last;

   assign w_start_ok = (r_state == ST_IDLE) && bus.start && (bus.frame_len != '0);
   // abort wins over a bit arriving in the same cycle
   assign w_shift    = (r_state == ST_RUN) && bus.din_vld && !bus.abort;
   assign w_last     = (LEN_W'(r_bitcnt + 1'b1) == r_flen);

   seq_pat_match #(.PAT_W(PAT_W)) u_match (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_start_ok),
      .i_shift (w_shift),
      .i_din   (bus.din),
      .i_pat   (r_pat),
      .i_len   (r_len),
      .i_ovl   (r_ovl),
      .o_hit   (w_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_pat    <= DEF_PAT[PAT_W-1:0];
         r_len    <= DEF_LEN;
         r_ovl    <= DEF_OVL;
         r_flen   <= '0;
         r_bitcnt <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_match  <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_match <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // config lands first so a same-cycle start uses it
               if (bus.cfg_we) begin
                  if (len_ok(bus.cfg_len, PAT_W)) begin
                     r_pat <= bus.cfg_pat;
                     r_len <= bus.cfg_len;
                     r_ovl <= bus.cfg_ovl;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
               if (bus.start) begin
                  if (w_start_ok) begin
                     r_flen   <= bus.frame_len;
                     r_bitcnt <= '0;
                     r_cnt    <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= ST_RUN;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end

            ST_RUN: begin
               if (bus.cfg_we)
                  r_err <= 1'b1;
               if (bus.abort) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (bus.din_vld) begin
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (w_hit) begin
                     r_match <= 1'b1;
                     if (r_cnt != '1)
                        r_cnt <= r_cnt + 1'b1;
                  end
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               // done/match for the final bit are already on the outputs
               if (bus.cfg_we)
                  r_err <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.match     = r_match;
   assign bus.match_cnt = r_cnt;
   assign bus.done      = r_done;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_frame_ctrl
// Directed scenarios followed by random traffic, every cycle compared with a
// frame-level reference model (bit queue + last-hit position).
// -----------------------------------------------------------------------------
module tb_seq_frame_ctrl;

   localparam int PW   = 8;
   localparam int CW   = 3;
   localparam int LW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seq_frame_ctrl_if #(.PAT_W(PW), .CNT_W(CW), .LEN_W(LW)) bus ();

   seq_frame_ctrl #(.PAT_W(PW), .CNT_W(CW), .LEN_W(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   int         m_st;      // 0 idle, 1 running, 2 frame just ended
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   int         m_flen;
   bit         m_bits[$];
   int         m_last;
   int         m_cnt;
   int         e_busy, e_match, e_cnt, e_done, e_err;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_pat = 8'b101; m_len = 3; m_ovl = 1'b1;
      m_flen = 0; m_bits.delete(); m_last = 0; m_cnt = 0;
      e_busy = 0; e_match = 0; e_cnt = 0; e_done = 0; e_err = 0;
   endtask

   task automatic model_step(input bit we, input logic [7:0] pat, input int len,
                             input bit ov, input bit st, input int fl,
                             input bit ab, input bit d, input bit dv);
      int n;
      bit hit;
      e_match = 0; e_done = 0; e_err = 0;
      case (m_st)
         0: begin
            if (we) begin
               if (len >= 1 && len <= PW) begin
                  m_pat = pat; m_len = len; m_ovl = ov;
               end else e_err = 1;
            end
            if (st) begin
               if (fl != 0) begin
                  m_flen = fl; m_bits.delete(); m_last = 0; m_cnt = 0; m_st = 1;
               end else e_err = 1;
            end
         end
         1: begin
            if (we) e_err = 1;
            if (ab) m_st = 0;
            else if (dv) begin
               m_bits.push_back(d);
               n   = m_bits.size();
               // enough bits since frame start (or since last consumed hit)
               hit = (n - m_last) >= m_len;
               if (hit)
                  for (int k = 0; k < m_len; k++)
                     if (m_bits[n-1-k] != m_pat[k]) hit = 0;
               if (hit) begin
                  e_match = 1;
                  if (m_cnt < CMAX) m_cnt++;
                  if (!m_ovl) m_last = n;
               end
               if (n == m_flen) begin
                  e_done = 1; m_st = 2;
               end
            end
         end
         default: begin
            if (we) e_err = 1;
            m_st = 0;
         end
      endcase
      e_busy = (m_st != 0);
      e_cnt  = m_cnt;
   endtask

   task automatic check_all();
      chk("busy",  int'(bus.busy),      e_busy);
      chk("match", int'(bus.match),     e_match);
      chk("cnt",   int'(bus.match_cnt), e_cnt);
      chk("done",  int'(bus.done),      e_done);
      chk("err",   int'(bus.err),       e_err);
   endtask

   // One clock: drive at negedge, advance model, check just after posedge.
   task automatic cyc(input bit we, input logic [7:0] pat, input logic [3:0] len,
                      input bit ov, input bit st, input logic [7:0] fl,
                      input bit ab, input bit d, input bit dv);
      @(negedge clk);
      bus.cfg_we = we;  bus.cfg_pat = pat; bus.cfg_len = len; bus.cfg_ovl = ov;
      bus.start  = st;  bus.frame_len = fl; bus.abort = ab;
      bus.din    = d;   bus.din_vld = dv;
      model_step(we, pat, int'(len), ov, st, int'(fl), ab, d, dv);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      cyc(0, 8'h0, 4'd0, 0, 0, 8'd0, 0, 0, 0);
   endtask

   task automatic start_frame(input logic [7:0] fl);
      cyc(0, 8'h0, 4'd0, 0, 1, fl, 0, 0, 0);
   endtask

   task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input bit ov);
      cyc(1, pat, len, ov, 0, 8'd0, 0, 0, 0);
   endtask

   // s[0] is the first bit sent; maxgap>0 inserts 1..maxgap idle cycles
   task automatic run_stream(input logic [15:0] s, input int n, input int maxgap);
      for (int i = 0; i < n; i++) begin
         if (maxgap > 0 && i > 0) begin
            int g;
            g = int'($urandom_range(1, maxgap));
            for (int j = 0; j < g; j++)
               cyc(0, 8'h0, 4'd0, 0, 0, 8'd0, 0, 1'($urandom), 0);
         end
         cyc(0, 8'h0, 4'd0, 0, 0, 8'd0, 0, s[i], 1);
      end
   endtask

   localparam logic [15:0] S1 = 16'h00B5;   // 1,0,1,0,1,1,0,1
   localparam logic [15:0] S2 = 16'h0036;   // 0,1,1,0,1,1,0

   initial begin
      bus.cfg_we = 0; bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_ovl = 0;
      bus.start = 0; bus.frame_len = '0; bus.abort = 0; bus.din = 0; bus.din_vld = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_busy",  int'(bus.busy), 0);
      chk("rst_match", int'(bus.match), 0);
      chk("rst_cnt",   int'(bus.match_cnt), 0);
      chk("rst_done",  int'(bus.done), 0);
      chk("rst_err",   int'(bus.err), 0);
      rst = 1'b0;

      // default 101, overlapping
      start_frame(8'd8);
      run_stream(S1, 8, 0);
      chk("s1_done",  int'(bus.done), 1);
      chk("s1_match", int'(bus.match), 1);
      chk("s1_cnt",   int'(bus.match_cnt), 3);
      idle();
      chk("s1_busy_fall", int'(bus.busy), 0);
      chk("s1_cnt_hold",  int'(bus.match_cnt), 3);

      // same stream with invalid gaps
      start_frame(8'd8);
      run_stream(S1, 8, 3);
      chk("gap_cnt", int'(bus.match_cnt), 3);
      idle();

      // non-overlap, config written in the same cycle as start
      cyc(1, 8'b101, 4'd3, 0, 1, 8'd8, 0, 0, 0);
      run_stream(S1, 8, 0);
      chk("novl_cnt", int'(bus.match_cnt), 2);
      idle();

      // 4-bit pattern 0110
      cfg(8'b0110, 4'd4, 1);
      start_frame(8'd7);
      run_stream(S2, 7, 0);
      chk("repr_cnt", int'(bus.match_cnt), 2);
      idle();

      // back to defaults, then rejected commands
      cfg(8'b101, 4'd3, 1);
      start_frame(8'd0);
      chk("st0_err",  int'(bus.err), 1);
      chk("st0_busy", int'(bus.busy), 0);
      cfg(8'h0F, 4'd0, 0);
      chk("len0_err", int'(bus.err), 1);
      cfg(8'h0F, 4'd9, 0);
      chk("len9_err", int'(bus.err), 1);
      start_frame(8'd8);
      cyc(1, 8'h0F, 4'd4, 0, 0, 8'd0, 0, 0, 0);   // cfg_we while busy
      chk("run_we_err", int'(bus.err), 1);
      run_stream(S1, 8, 0);
      chk("cfg_kept_cnt", int'(bus.match_cnt), 3);
      idle();

      // counter saturation with a 1-bit pattern
      cfg(8'b1, 4'd1, 1);
      start_frame(8'd12);
      run_stream(16'hFFFF, 12, 0);
      chk("sat_cnt", int'(bus.match_cnt), CMAX);
      idle();
      cfg(8'b101, 4'd3, 1);

      // abort after 4 bits, abort beats a hitting bit in the same cycle
      start_frame(8'd8);
      run_stream(S1, 4, 0);
      cyc(0, 8'h0, 4'd0, 0, 0, 8'd0, 1, 1, 1);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_cnt",  int'(bus.match_cnt), 1);
      idle();

      // asynchronous reset between clock edges
      start_frame(8'd8);
      run_stream(S1, 5, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_cnt",  int'(bus.match_cnt), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] len;
         len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(1, 3));
         cyc($urandom_range(0, 9) == 0, 8'($urandom), len, 1'($urandom),
             $urandom_range(0, 5) == 0,
             ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 24)),
             $urandom_range(0, 39) == 0, 1'($urandom),
             $urandom_range(0, 3) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_frame_ctrl.md
Name: seq_frame_ctrl

Overview:
Programmable serial pattern-detection controller. It generalises the fixed "101" detector into a runtime-configurable engine:
- pattern of 1..PAT_W bits, with overlap or non-overlap matching;
- frames of a programmed bit count;
- per-frame match counting, with start, abort and done handshakes.

It sits between a bus/config agent and a bit-serial input stream.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..15)
CNT_W, 8, width of match counter (saturating)
LEN_W, 8, width of frame length / bit counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
cfg_we  in  1  config write strobe (accepted in IDLE only)
cfg_pat  in  PAT_W  pattern; cfg_pat[0] = most recent bit, cfg_pat[L-1] = oldest
cfg_len  in  4  pattern length L, valid range 1..PAT_W
cfg_ovl  in  1  1 = overlapping matches allowed
start  in  1  begin frame (IDLE only)
frame_len  in  LEN_W  bits in frame, sampled on accepted start; 0 is invalid
abort  in  1  terminate frame, no done pulse
din  in  1  serial data bit
din_vld  in  1  din valid this cycle
busy  out  1  state != IDLE
match  out  1  one-cycle registered match pulse
match_cnt  out  CNT_W  matches in current/last frame
done  out  1  one-cycle frame-complete pulse
err  out  1  one-cycle rejected-command pulse

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; it forces IDLE immediately, at any time.
- Reset values:
  - Outputs: busy=0, match=0, match_cnt=0, done=0, err=0.
  - Internal: history=0, fill=0, bit count=0.
  - Config: pattern=...0101, L=3, ovl=1 (legacy 101-detector behaviour).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_we with 1<=cfg_len<=PAT_W latches pat/len/ovl.
  - cfg_we with cfg_len outside that range is ignored, and err pulses the next cycle.
  - start with frame_len!=0 does all of the following:
    - latches frame_len;
    - clears history, fill, bit count and match_cnt;
    - moves to RUN.
  - start with frame_len==0 causes an err pulse and the block stays in IDLE.
  - If start and cfg_we occur in the same cycle, cfg_we is applied first. The frame then uses the new config.
- RUN, on each edge with din_vld=1:
  - hist <= {hist[PAT_W-2:0], din}; fill <= min(fill+1, PAT_W); bitcnt++.
  - A hit occurs when fill_next>=L AND hist_next[L-1:0]==pat[L-1:0].
  - On a hit: match=1 in the following cycle, and match_cnt increments, saturating at 2^CNT_W-1.
  - Non-overlap mode: a hit also sets fill to 0, so the next match needs L fresh bits.
  - Cycles with din_vld=0 change nothing.
- End of frame: the edge that makes bitcnt==frame_len still evaluates its bit, then moves to DONE.
- DONE: lasts one cycle. done=1, plus match=1 if the last bit hit. Then the FSM returns to IDLE.
- Command errors:
  - cfg_we while busy is ignored and pulses err.
  - start while busy is ignored silently.
- abort in RUN or DONE: the FSM goes to IDLE at the next edge.
  - No done pulse is produced; if DONE was already reached, done for that cycle is still driven.
  - match_cnt holds its value.
  - abort takes priority over a din_vld bit in the same cycle; that bit is discarded.
- Output timing: all outputs are registered; there are no combinational paths from inputs to outputs.
- match_cnt is stable from done until the next accepted start.

Decomposition:
- Shared package seq_pkg:
  - state encoding constants (IDLE/RUN/DONE);
  - reset defaults (DEF_PAT=101, DEF_LEN=3, DEF_OVL=1).
- One natural sub-module: seq_pat_match.
  - Contains the history shift register, fill counter and masked compare, with L/ovl/pat inputs and a hit output.
  - Leaves the controller holding the FSM, counters and error logic.

Test Plan:
- Defaults: rst, start frame_len=8, stream 1,0,1,0,1,1,0,1 at every clock -> match after bits 3, 5, 8; match_cnt=3; one done pulse coincident with the final match; busy falls the cycle after done.
- Non-overlap: cfg_ovl=0, L=3, pat=101, same stream -> matches after bits 3 and 8 only; match_cnt=2.
- Valid gaps: repeat the first scenario with 1-3 din_vld=0 cycles between bits -> identical matches and count; done only after the 8th valid bit.
- Reprogram: pat=0110, L=4, ovl=1, frame_len=7, stream 0,1,1,0,1,1,0 -> matches after bits 4 and 7; match_cnt=2.
- Errors:
  - cfg_we during RUN -> err pulse, config unchanged;
  - start with frame_len=0 -> err, busy stays 0;
  - cfg_len=0 or 9 -> err, config unchanged.
- Abort and reset:
  - abort after 4 bits of the first scenario's stream -> IDLE next cycle, no done, match_cnt=1;
  - rst asserted mid-frame, between clock edges -> busy and match_cnt clear immediately, without waiting for a clock edge.
